// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the RV32I decode stage.
// The slave modport is the decode view; the master modport drives fetch/execute.
interface decode_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [AWIDTH-1:0] pc_i;
  logic [DWIDTH-1:0] insn_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;
  logic [6:0]        opcode_o;
  logic [4:0]        rd_o;
  logic [2:0]        funct3_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic [6:0]        funct7_o;
  logic [31:0]       imm_o;
  logic              illegal_o;

  modport slave (
    input  in_valid_i, pc_i, insn_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, funct3_o,
           rs1_o, rs2_o, funct7_o, imm_o, illegal_o
  );

  modport master (
    output in_valid_i, pc_i, insn_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, funct3_o,
           rs1_o, rs2_o, funct7_o, imm_o, illegal_o
  );
endinterface

// File: rtl/decode.sv
// RV32I decode stage: decodes the incoming beat combinationally and registers the
// result into a main/skid pair so every output, including in_ready_o, is a flop.
module decode #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  decode_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [AWIDTH-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [DWIDTH-1:0] main_insn_q, main_insn_d, skid_insn_q, skid_insn_d;
  logic [31:0]       main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic              main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;

  logic [31:0] dec_imm;
  logic        dec_ill;
  logic        accept;
  logic        xfer;

  always_comb begin
    dec_imm = 32'd0;
    dec_ill = 1'b0;
    case (bus.insn_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011:
        dec_imm = {{20{bus.insn_i[31]}}, bus.insn_i[31:20]};
      7'b0100011:
        dec_imm = {{20{bus.insn_i[31]}}, bus.insn_i[31:25], bus.insn_i[11:7]};
      7'b1100011:
        dec_imm = {{19{bus.insn_i[31]}}, bus.insn_i[31], bus.insn_i[7],
                   bus.insn_i[30:25], bus.insn_i[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        dec_imm = {bus.insn_i[31:12], 12'd0};
      7'b1101111:
        dec_imm = {{11{bus.insn_i[31]}}, bus.insn_i[31], bus.insn_i[19:12],
                   bus.insn_i[20], bus.insn_i[30:21], 1'b0};
      7'b0110011:
        dec_imm = 32'd0;
      default:
        dec_ill = 1'b1;
    endcase
  end

  assign accept = bus.in_valid_i && in_ready_q;
  assign xfer   = (state_q != EMPTY) && bus.out_ready_i;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_insn_d = main_insn_q;
    main_imm_d  = main_imm_q;
    main_ill_d  = main_ill_q;
    skid_pc_d   = skid_pc_q;
    skid_insn_d = skid_insn_q;
    skid_imm_d  = skid_imm_q;
    skid_ill_d  = skid_ill_q;

    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = BUSY;
            main_pc_d   = bus.pc_i;
            main_insn_d = bus.insn_i;
            main_imm_d  = dec_imm;
            main_ill_d  = dec_ill;
          end
        end
        BUSY: begin
          // Execute stalled: park the new beat in skid behind the one on the outputs.
          if (accept && !xfer) begin
            state_d     = FULL;
            skid_pc_d   = bus.pc_i;
            skid_insn_d = bus.insn_i;
            skid_imm_d  = dec_imm;
            skid_ill_d  = dec_ill;
          end else if (accept && xfer) begin
            main_pc_d   = bus.pc_i;
            main_insn_d = bus.insn_i;
            main_imm_d  = dec_imm;
            main_ill_d  = dec_ill;
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (xfer) begin
            state_d     = BUSY;
            main_pc_d   = skid_pc_q;
            main_insn_d = skid_insn_q;
            main_imm_d  = skid_imm_q;
            main_ill_d  = skid_ill_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_pc_q   <= '0;
      main_insn_q <= '0;
      main_imm_q  <= '0;
      main_ill_q  <= 1'b0;
      skid_pc_q   <= '0;
      skid_insn_q <= '0;
      skid_imm_q  <= '0;
      skid_ill_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_pc_q   <= main_pc_d;
      main_insn_q <= main_insn_d;
      main_imm_q  <= main_imm_d;
      main_ill_q  <= main_ill_d;
      skid_pc_q   <= skid_pc_d;
      skid_insn_q <= skid_insn_d;
      skid_imm_q  <= skid_imm_d;
      skid_ill_q  <= skid_ill_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = (state_q != EMPTY);
  assign bus.pc_o        = main_pc_q;
  assign bus.insn_o      = main_insn_q;
  assign bus.opcode_o    = main_insn_q[6:0];
  assign bus.rd_o        = main_insn_q[11:7];
  assign bus.funct3_o    = main_insn_q[14:12];
  assign bus.rs1_o       = main_insn_q[19:15];
  assign bus.rs2_o       = main_insn_q[24:20];
  assign bus.funct7_o    = main_insn_q[31:25];
  assign bus.imm_o       = main_imm_q;
  assign bus.illegal_o   = main_ill_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: a vector table for field/immediate decode,
// plus hand-written backpressure, flush and async-reset sequences.
module tb_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  decode_if #(.AWIDTH(32), .DWIDTH(32)) dif ();

  decode #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct {
    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn);
    dif.in_valid_i = v;
    dif.pc_i       = pc;
    dif.insn_i     = insn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          insn          opc    rd     f3    rs1    rs2    f7     imm           ill
    vecs[0] = '{32'h00500093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd5,  7'h00, 32'h00000005, 1'b0};
    vecs[1] = '{32'hFFF00093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{32'h0020A423, 7'h23, 5'd8,  3'd2, 5'd1,  5'd2,  7'h00, 32'h00000008, 1'b0};
    vecs[3] = '{32'hFE000EE3, 7'h63, 5'd29, 3'd0, 5'd0,  5'd0,  7'h7F, 32'hFFFFFFFC, 1'b0};
    vecs[4] = '{32'h123452B7, 7'h37, 5'd5,  3'd5, 5'd8,  5'd3,  7'h09, 32'h12345000, 1'b0};
    vecs[5] = '{32'h008000EF, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd8,  7'h00, 32'h00000008, 1'b0};
    vecs[6] = '{32'h00001117, 7'h17, 5'd2,  3'd1, 5'd0,  5'd0,  7'h00, 32'h00001000, 1'b0};
    vecs[7] = '{32'h002081B3, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 32'h00000000, 1'b0};
    vecs[8] = '{32'h00000000, 7'h00, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000, 1'b1};
    vecs[9] = '{32'h0000007F, 7'h7F, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000, 1'b1};

    drive(1'b0, 32'd0, 32'd0);
    dif.flush_i     = 1'b0;
    dif.out_ready_i = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, dif.out_valid_o}, 32'd0);
    check("rst_in_ready", {31'd0, dif.in_ready_o}, 32'd1);
    check("rst_imm", dif.imm_o, 32'd0);
    check("rst_illegal", {31'd0, dif.illegal_o}, 32'd0);
    check("rst_pc", dif.pc_o, 32'd0);
    check("rst_insn", dif.insn_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table, one beat per cycle with execute always ready
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), vecs[i].insn);
      @(negedge clk);
      drive(1'b0, 32'd0, 32'd0);
      check($sformatf("v%0d_valid", i), {31'd0, dif.out_valid_o}, 32'd1);
      check($sformatf("v%0d_pc", i), dif.pc_o, 32'h100 + 32'(4 * i));
      check($sformatf("v%0d_insn", i), dif.insn_o, vecs[i].insn);
      check($sformatf("v%0d_opcode", i), {25'd0, dif.opcode_o}, {25'd0, vecs[i].opcode});
      check($sformatf("v%0d_rd", i), {27'd0, dif.rd_o}, {27'd0, vecs[i].rd});
      check($sformatf("v%0d_funct3", i), {29'd0, dif.funct3_o}, {29'd0, vecs[i].funct3});
      check($sformatf("v%0d_rs1", i), {27'd0, dif.rs1_o}, {27'd0, vecs[i].rs1});
      check($sformatf("v%0d_rs2", i), {27'd0, dif.rs2_o}, {27'd0, vecs[i].rs2});
      check($sformatf("v%0d_funct7", i), {25'd0, dif.funct7_o}, {25'd0, vecs[i].funct7});
      check($sformatf("v%0d_imm", i), dif.imm_o, vecs[i].imm);
      check($sformatf("v%0d_illegal", i), {31'd0, dif.illegal_o}, {31'd0, vecs[i].ill});
      $display("[TB] vector %0d insn 0x%08h imm 0x%08h ill %0d", i, dif.insn_o, dif.imm_o, dif.illegal_o);
    end
    @(negedge clk);
    check("drain_empty", {31'd0, dif.out_valid_o}, 32'd0);

    // Backpressure: two beats fill main+skid, third waits, order preserved
    dif.out_ready_i = 1'b0;
    drive(1'b1, 32'h01000000, 32'h00000013);
    @(negedge clk);
    check("bp_ready_busy", {31'd0, dif.in_ready_o}, 32'd1);
    check("bp_pc_a", dif.pc_o, 32'h01000000);
    drive(1'b1, 32'h01000004, 32'h00100013);
    @(negedge clk);
    check("bp_ready_full", {31'd0, dif.in_ready_o}, 32'd0);
    drive(1'b1, 32'h01000008, 32'h00200013);
    @(negedge clk);
    check("bp_ready_hold", {31'd0, dif.in_ready_o}, 32'd0);
    check("bp_pc_hold", dif.pc_o, 32'h01000000);
    check("bp_imm_hold", dif.imm_o, 32'd0);
    dif.out_ready_i = 1'b1;
    @(negedge clk);
    check("bp_pc_b", dif.pc_o, 32'h01000004);
    check("bp_imm_b", dif.imm_o, 32'd1);
    check("bp_ready_again", {31'd0, dif.in_ready_o}, 32'd1);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0);
    check("bp_pc_c", dif.pc_o, 32'h01000008);
    check("bp_imm_c", dif.imm_o, 32'd2);
    check("bp_valid_c", {31'd0, dif.out_valid_o}, 32'd1);
    @(negedge clk);
    check("bp_empty", {31'd0, dif.out_valid_o}, 32'd0);
    $display("[TB] backpressure sequence done");

    // Flush in FULL with a beat offered in the same cycle
    dif.out_ready_i = 1'b0;
    drive(1'b1, 32'h02000000, 32'h00000013);
    @(negedge clk);
    drive(1'b1, 32'h02000004, 32'h00000013);
    @(negedge clk);
    check("fl_full", {31'd0, dif.in_ready_o}, 32'd0);
    drive(1'b1, 32'h02000008, 32'h00000013);
    dif.flush_i = 1'b1;
    @(negedge clk);
    dif.flush_i = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    check("fl_valid", {31'd0, dif.out_valid_o}, 32'd0);
    check("fl_ready", {31'd0, dif.in_ready_o}, 32'd1);
    dif.out_ready_i = 1'b1;
    @(negedge clk);
    check("fl_stays_empty", {31'd0, dif.out_valid_o}, 32'd0);
    drive(1'b1, 32'h0200000C, 32'h00500093);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0);
    check("fl_next_pc", dif.pc_o, 32'h0200000C);
    check("fl_next_valid", {31'd0, dif.out_valid_o}, 32'd1);
    @(negedge clk);
    check("fl_no_ghost", {31'd0, dif.out_valid_o}, 32'd0);
    $display("[TB] flush sequence done");

    // Async reset while BUSY
    dif.out_ready_i = 1'b0;
    drive(1'b1, 32'h03000000, 32'hFFF00093);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0);
    check("ar_busy", {31'd0, dif.out_valid_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, dif.out_valid_o}, 32'd0);
    check("ar_ready", {31'd0, dif.in_ready_o}, 32'd1);
    check("ar_imm", dif.imm_o, 32'd0);
    check("ar_pc", dif.pc_o, 32'd0);
    check("ar_insn", dif.insn_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dif.out_ready_i = 1'b1;
    drive(1'b1, 32'h04000000, 32'h00500093);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0);
    check("ar_after_valid", {31'd0, dif.out_valid_o}, 32'd1);
    check("ar_after_imm", dif.imm_o, 32'd5);
    check("ar_after_rd", {27'd0, dif.rd_o}, 32'd1);
    check("ar_after_opcode", {25'd0, dif.opcode_o}, 32'h13);
    check("ar_after_illegal", {31'd0, dif.illegal_o}, 32'd0);
    $display("[TB] async reset sequence done");

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
